// File: rtl/simon_autoplayer_pkg.sv
// Shared game definitions: autoplayer state encoding and flash LED patterns.
// The flash-display block uses the same pattern constants, so both sides agree
// on which LED means which bit.
package simon_autoplayer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CAPTURE = 3'd1,
      ST_GAP     = 3'd2,
      ST_PRESS   = 3'd3,
      ST_DONE    = 3'd4
   } ap_state_e;

   localparam logic [1:0] FLASH_DARK    = 2'b00;
   localparam logic [1:0] FLASH_RIGHT   = 2'b01;  // bit 0
   localparam logic [1:0] FLASH_LEFT    = 2'b10;  // bit 1
   localparam logic [1:0] FLASH_ILLEGAL = 2'b11;

   // True for the two patterns that carry a sequence bit.
   function automatic logic is_bit_flash(input logic [1:0] f);
      return (f == FLASH_LEFT) || (f == FLASH_RIGHT);
   endfunction

endpackage

// File: rtl/simon_autoplayer_if.sv
// Game-side link between the autoplayer and the Simon game: the game shows
// flashes and marks the end of a sequence, the autoplayer drives the buttons.
interface simon_autoplayer_if;
   logic [1:0] flash;
   logic       flash_done;
   logic       press_left;
   logic       press_right;

   // Autoplayer side.
   modport master (
      input  flash,
      input  flash_done,
      output press_left,
      output press_right
   );

   // Game side.
   modport slave (
      output flash,
      output flash_done,
      input  press_left,
      input  press_right
   );
endinterface

// File: rtl/simon_autoplayer_timer.sv
// Loadable down-counter used for both the release gap and the press hold.
// Loading N-1 makes the owner wait N cycles; the count sticks at zero, so it
// never wraps while the owner is waiting to act on done.
module autoplayer_timer #(
   parameter int WIDTH = 21
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: load wins, otherwise count down and hold at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done = (cnt_q == '0);

endmodule

// File: rtl/simon_autoplayer.sv
// Simon autoplayer: watches the flashed bit sequence, then replays it as
// timed button presses with a release gap before each press.
module simon_autoplayer
   import simon_autoplayer_pkg::*;
#(
   parameter int PRESS_CYCLES = 2000000,
   parameter int GAP_CYCLES   = 2000000,
   parameter int MAX_BITS     = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable,
   simon_autoplayer_if.master  game,
   output logic                busy,
   output logic [3:0]          seq_len,
   output logic                error
);

   localparam int TMAX = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] GAP_VAL   = TW'(GAP_CYCLES - 1);
   localparam logic [TW-1:0] PRESS_VAL = TW'(PRESS_CYCLES - 1);
   localparam logic [3:0]    MAX_LEN   = 4'(MAX_BITS);

   ap_state_e             state_q, state_d;
   logic [3:0]            seq_len_q, seq_len_d;
   logic [3:0]            idx_q, idx_d;
   logic [MAX_BITS-1:0]   bits_q, bits_d;
   logic [1:0]            flash_prev_q, flash_prev_d;
   logic                  error_q, error_d;
   logic                  press_left_q, press_left_d;
   logic                  press_right_q, press_right_d;

   logic                  tmr_load;
   logic [TW-1:0]         tmr_val;
   logic                  tmr_done;
   logic                  flash_edge;
   logic                  cur_bit;

   // Stored bit at a 4-bit index; indices past MAX_BITS read as 0.
   function automatic logic pick_bit(input logic [MAX_BITS-1:0] b, input logic [3:0] i);
      logic r;
      r = 1'b0;
      for (int k = 0; k < MAX_BITS; k++) begin
         if (k == int'(i)) r = b[k];
      end
      return r;
   endfunction

   autoplayer_timer #(.WIDTH(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // A bit is recorded only on a dark-to-bit transition; 11 is not dark.
   assign flash_edge = (flash_prev_q == FLASH_DARK) && is_bit_flash(game.flash);

   // Next-state, capture/replay bookkeeping and registered press levels.
   always_comb begin
      state_d       = state_q;
      seq_len_d     = seq_len_q;
      idx_d         = idx_q;
      bits_d        = bits_q;
      error_d       = error_q;
      flash_prev_d  = game.flash;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      press_left_d  = 1'b0;
      press_right_d = 1'b0;
      cur_bit       = 1'b0;

      case (state_q)
         ST_IDLE: begin
            seq_len_d = '0;
            idx_d     = '0;
            bits_d    = '0;
            tmr_load  = 1'b1;
            tmr_val   = '0;
            if (enable) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (game.flash == FLASH_ILLEGAL) begin
               error_d = 1'b1;
            end else if (flash_edge) begin
               if (seq_len_q == MAX_LEN) begin
                  error_d = 1'b1;
               end else begin
                  for (int k = 0; k < MAX_BITS; k++) begin
                     if (k == int'(seq_len_q)) bits_d[k] = (game.flash == FLASH_LEFT);
                  end
                  seq_len_d = seq_len_q + 4'd1;
               end
            end
            if (game.flash_done && (seq_len_d != '0)) begin
               state_d  = ST_GAP;
               idx_d    = '0;
               tmr_load = 1'b1;
               tmr_val  = GAP_VAL;
            end
         end
         ST_GAP: begin
            if (tmr_done) begin
               state_d  = ST_PRESS;
               tmr_load = 1'b1;
               tmr_val  = PRESS_VAL;
            end
         end
         ST_PRESS: begin
            if (tmr_done) begin
               idx_d = idx_q + 4'd1;
               if (idx_d < seq_len_q) begin
                  state_d  = ST_GAP;
                  tmr_load = 1'b1;
                  tmr_val  = GAP_VAL;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            seq_len_d = '0;
            bits_d    = '0;
            idx_d     = '0;
            state_d   = ST_CAPTURE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Losing enable always parks the block; error is deliberately kept.
      if (!enable) begin
         state_d  = ST_IDLE;
         tmr_load = 1'b1;
         tmr_val  = '0;
      end

      // Press levels follow the state being entered so they line up with PRESS.
      cur_bit = pick_bit(bits_d, idx_d);
      if (state_d == ST_PRESS) begin
         press_left_d  = cur_bit;
         press_right_d = !cur_bit;
      end
   end

   // State and data registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         seq_len_q     <= '0;
         idx_q         <= '0;
         bits_q        <= '0;
         flash_prev_q  <= FLASH_DARK;
         error_q       <= 1'b0;
         press_left_q  <= 1'b0;
         press_right_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         seq_len_q     <= seq_len_d;
         idx_q         <= idx_d;
         bits_q        <= bits_d;
         flash_prev_q  <= flash_prev_d;
         error_q       <= error_d;
         press_left_q  <= press_left_d;
         press_right_q <= press_right_d;
      end
   end

   assign busy             = (state_q != ST_IDLE);
   assign seq_len          = seq_len_q;
   assign error            = error_q;
   assign game.press_left  = press_left_q;
   assign game.press_right = press_right_q;

endmodule
